mvm_uart_seq: RTL and testbench

Frame sequencer between the UART byte streams and the matrix-vector multiply engine in the UART MVM system. It assembles received bytes into the packed weight matrix K and input vector X, issues one start pulse to the MVM engine, waits for its done, then serializes the packed result Y into bytes for the UART transmitter. It is the only block that drives the engine's operands and start.

---
 rtl/mvm_uart_seq.sv | 195 +++++++++++++++++++
 tb/tb_mvm_uart_seq.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mvm_uart_seq.sv
`default_nettype none
// ============================================================================
// Module   : mvm_uart_seq
// Brief    : Frame sequencer between the UART byte streams and the MVM engine.
//            Collects K then X bytes (little-endian), pulses mvm_start, waits
//            for mvm_done, then streams the captured Y out byte by byte.
//            Optional inter-byte idle timeout: define MVM_UART_SEQ_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mvm_uart_seq #(
    parameter int R             = 4,
    parameter int C             = 4,
    parameter int W_X           = 4,
    parameter int W_K           = 2,
    parameter int W_Y_OUT       = 10,
    parameter int BITS_PER_WORD = 8,
    parameter int TIMEOUT_CLKS  = 4096
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [BITS_PER_WORD-1:0]   rx_data,
    input  logic                       rx_valid,
    output logic [R*C*W_K-1:0]         k_flat,
    output logic [C*W_X-1:0]           x_flat,
    output logic                       mvm_start,
    input  logic                       mvm_done,
    input  logic [R*W_Y_OUT-1:0]       y_flat,
    output logic [BITS_PER_WORD-1:0]   tx_data,
    output logic                       tx_valid,
    input  logic                       tx_ready,
    output logic                       busy,
    output logic                       err_overrun
);

    localparam int c_k_bits  = R * C * W_K;
    localparam int c_x_bits  = C * W_X;
    localparam int c_y_bits  = R * W_Y_OUT;
    localparam int c_nk      = (c_k_bits + BITS_PER_WORD - 1) / BITS_PER_WORD;
    localparam int c_nx      = (c_x_bits + BITS_PER_WORD - 1) / BITS_PER_WORD;
    localparam int c_ny      = (c_y_bits + BITS_PER_WORD - 1) / BITS_PER_WORD;
    localparam int c_k_pad_w = c_nk * BITS_PER_WORD;
    localparam int c_x_pad_w = c_nx * BITS_PER_WORD;
    localparam int c_y_pad_w = c_ny * BITS_PER_WORD;
    localparam int c_nmax    = (c_nk > c_nx) ? ((c_nk > c_ny) ? c_nk : c_ny)
                                             : ((c_nx > c_ny) ? c_nx : c_ny);
    localparam int c_cnt_w   = (c_nmax > 1) ? $clog2(c_nmax) : 1;

    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_nk_last = c_cnt_w'(c_nk - 1);
    localparam logic [c_cnt_w-1:0] c_nx_last = c_cnt_w'(c_nx - 1);
    localparam logic [c_cnt_w-1:0] c_ny_last = c_cnt_w'(c_ny - 1);

    typedef enum logic [2:0] {
        S_RX_K  = 3'd0,
        S_RX_X  = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_TX    = 3'd4
    } state_t;

    state_t                   r_state;
    logic [c_cnt_w-1:0]       r_cnt;
    logic [c_k_pad_w-1:0]     r_k_pad;
    logic [c_x_pad_w-1:0]     r_x_pad;
    logic [c_y_pad_w-1:0]     r_y_pad;
    logic                     r_start;
    logic                     r_tx_valid;
    logic                     r_overrun;
    logic                     w_timeout;
    logic [BITS_PER_WORD-1:0] w_tx_byte;

`ifdef MVM_UART_SEQ_TIMEOUT_EN
    logic [15:0] r_idle;
    logic        w_idle_run;

    // RX_X always holds a partial frame, even right after its counter reset
    assign w_idle_run = (r_state == S_RX_X) || ((r_state == S_RX_K) && (r_cnt != '0));
    assign w_timeout  = w_idle_run && !rx_valid && (r_idle == 16'(TIMEOUT_CLKS - 1));

    always_ff @(posedge clk) begin
        if (rst || !w_idle_run || rx_valid || w_timeout) begin
            r_idle <= '0;
        end else begin
            r_idle <= r_idle + 16'd1;
        end
    end
`else
    // Timeout length is irrelevant without the idle counter
    assign w_timeout = (TIMEOUT_CLKS < 0);
`endif

    always_comb begin
        w_tx_byte = '0;
        for (int i = 0; i < c_ny; i++) begin
            if (r_tx_valid && (r_cnt == c_cnt_w'(i))) begin
                w_tx_byte = r_y_pad[i*BITS_PER_WORD +: BITS_PER_WORD];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_RX_K;
            r_cnt      <= '0;
            r_k_pad    <= '0;
            r_x_pad    <= '0;
            r_y_pad    <= '0;
            r_start    <= 1'b0;
            r_tx_valid <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_start <= 1'b0;
            case (r_state)
                S_RX_K: begin
                    if (rx_valid) begin
                        for (int i = 0; i < c_nk; i++) begin
                            if (r_cnt == c_cnt_w'(i)) begin
                                r_k_pad[i*BITS_PER_WORD +: BITS_PER_WORD] <= rx_data;
                            end
                        end
                        if (r_cnt == c_nk_last) begin
                            r_cnt   <= '0;
                            r_state <= S_RX_X;
                        end else begin
                            r_cnt <= r_cnt + c_cnt_one;
                        end
                    end else if (w_timeout) begin
                        r_cnt <= '0;
                    end
                end
                S_RX_X: begin
                    if (rx_valid) begin
                        for (int i = 0; i < c_nx; i++) begin
                            if (r_cnt == c_cnt_w'(i)) begin
                                r_x_pad[i*BITS_PER_WORD +: BITS_PER_WORD] <= rx_data;
                            end
                        end
                        if (r_cnt == c_nx_last) begin
                            r_cnt   <= '0;
                            r_start <= 1'b1;
                            r_state <= S_START;
                        end else begin
                            r_cnt <= r_cnt + c_cnt_one;
                        end
                    end else if (w_timeout) begin
                        r_cnt   <= '0;
                        r_state <= S_RX_K;
                    end
                end
                S_START: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (mvm_done) begin
                        r_y_pad    <= c_y_pad_w'(y_flat);
                        r_cnt      <= '0;
                        r_tx_valid <= 1'b1;
                        r_state    <= S_TX;
                    end
                end
                S_TX: begin
                    if (tx_ready) begin
                        if (r_cnt == c_ny_last) begin
                            r_cnt      <= '0;
                            r_tx_valid <= 1'b0;
                            r_state    <= S_RX_K;
                        end else begin
                            r_cnt <= r_cnt + c_cnt_one;
                        end
                    end
                end
                default: begin
                    r_cnt      <= '0;
                    r_tx_valid <= 1'b0;
                    r_state    <= S_RX_K;
                end
            endcase

            // Bytes arriving while the engine owns the frame are dropped
            if (rx_valid && ((r_state == S_START) || (r_state == S_WAIT) || (r_state == S_TX))) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign k_flat      = r_k_pad[c_k_bits-1:0];
    assign x_flat      = r_x_pad[c_x_bits-1:0];
    assign mvm_start   = r_start;
    assign tx_data     = w_tx_byte;
    assign tx_valid    = r_tx_valid;
    assign busy        = !((r_state == S_RX_K) && (r_cnt == '0));
    assign err_overrun = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_mvm_uart_seq.sv
`default_nettype none
// Testbench for mvm_uart_seq: randomized frames against a byte-level reference
// model; a negedge monitor scores start operands and transmitted bytes.
module tb_mvm_uart_seq;

    localparam int R   = 4;
    localparam int C   = 4;
    localparam int W_X = 4;
    localparam int W_K = 2;
    localparam int W_Y = 10;
    localparam int BPW = 8;
    localparam int TMO = 16;
    localparam int NK  = (R*C*W_K + BPW - 1) / BPW;
    localparam int NX  = (C*W_X + BPW - 1) / BPW;
    localparam int NY  = (R*W_Y + BPW - 1) / BPW;

    typedef logic [7:0] bq_t[$];

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [BPW-1:0]       rx_data = '0;
    logic                 rx_valid = 1'b0;
    logic [R*C*W_K-1:0]   k_flat;
    logic [C*W_X-1:0]     x_flat;
    logic                 mvm_start;
    logic                 mvm_done = 1'b0;
    logic [R*W_Y-1:0]     y_flat = '0;
    logic [BPW-1:0]       tx_data;
    logic                 tx_valid;
    logic                 tx_ready = 1'b0;
    logic                 busy;
    logic                 err_overrun;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic        exp_ovr  = 1'b0;
    logic [31:0] cur_k;
    logic [15:0] cur_x;
    logic [47:0] exp_start_q[$];
    logic [7:0]  exp_tx_q[$];

    mvm_uart_seq #(
        .R(R), .C(C), .W_X(W_X), .W_K(W_K), .W_Y_OUT(W_Y),
        .BITS_PER_WORD(BPW), .TIMEOUT_CLKS(TMO)
    ) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .k_flat(k_flat), .x_flat(x_flat), .mvm_start(mvm_start),
        .mvm_done(mvm_done), .y_flat(y_flat), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy),
        .err_overrun(err_overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Little-endian byte assembly, truncated to the field width
    function automatic logic [63:0] le_pack(input bq_t q, input int first, input int n, input int width);
        logic [63:0] v = '0;
        for (int i = 0; i < n; i++) v |= 64'(q[first+i]) << (8*i);
        if (width < 64) v &= (64'd1 << width) - 64'd1;
        return v;
    endfunction

    always @(negedge clk) begin : monitor
        logic [47:0] e;
        if (!rst) begin
            if (mvm_start) begin
                if (exp_start_q.size() == 0) check("unexpected_start", 64'(mvm_start), 64'd0);
                else begin
                    e = exp_start_q.pop_front();
                    check("start_operands", 64'({k_flat, x_flat}), 64'(e));
                end
            end
            if (tx_valid) begin
                if (exp_tx_q.size() == 0) check("unexpected_tx", 64'(tx_valid), 64'd0);
                else begin
                    check("tx_byte", 64'(tx_data), 64'(exp_tx_q[0]));
                    if (tx_ready) e = 48'(exp_tx_q.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    function automatic bq_t rand_bytes(input int n);
        bq_t q;
        for (int i = 0; i < n; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    task automatic send_frame(input bq_t f, input bit gaps, input bit spurious, input int from);
        logic [63:0] v;
        v = le_pack(f, 0, NK, R*C*W_K);
        cur_k = 32'(v);
        v = le_pack(f, NK, NX, C*W_X);
        cur_x = 16'(v);
        exp_start_q.push_back({cur_k, cur_x});
        for (int i = from; i < NK + NX; i++) begin
            if (gaps) idle($urandom_range(0, 3));
            if (spurious && i == NK + 1) begin
                y_flat   = 40'hDE_ADBE_EF01;
                mvm_done = 1'b1;
                tick();
                mvm_done = 1'b0;
            end
            send_byte(f[i]);
        end
        check("start_latency", 64'(mvm_start), 64'd1);
    endtask

    task automatic do_result(input logic [39:0] y, input int mode, input bit wait_ovr, input bit last_ovr);
        int cyc;
        int hs;
        bit rdy;
        idle($urandom_range(1, 3));
        if (wait_ovr) begin
            rx_data  = 8'h55;
            rx_valid = 1'b1;
            tick();
            rx_valid = 1'b0;
            exp_ovr  = 1'b1;
            check("ovr_wait_flag", 64'(err_overrun), 64'd1);
            check("ovr_wait_k", 64'(k_flat), 64'(cur_k));
            check("ovr_wait_x", 64'(x_flat), 64'(cur_x));
            check("ovr_wait_busy", 64'(busy), 64'd1);
        end
        for (int j = 0; j < NY; j++) exp_tx_q.push_back(8'(y >> (8*j)));
        y_flat   = y;
        mvm_done = 1'b1;
        tick();
        mvm_done = 1'b0;
        y_flat   = 40'({$urandom, $urandom});
        check("tx_valid_latency", 64'(tx_valid), 64'd1);
        cyc = 0;
        hs  = 0;
        while (tx_valid && cyc < 200) begin
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = ($urandom_range(0, 1) == 1);
                default: rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
            endcase
            tx_ready = rdy;
            if (last_ovr && rdy && hs == NY - 1) begin
                rx_data  = 8'($urandom);
                rx_valid = 1'b1;
                exp_ovr  = 1'b1;
            end
            if (rdy) hs++;
            tick();
            rx_valid = 1'b0;
            cyc++;
        end
        tx_ready = 1'b0;
        check("tx_handshakes", 64'(hs), 64'(NY));
        if (mode == 0) check("tx_cycles", 64'(cyc), 64'(NY));
        check("busy_idle", 64'(busy), 64'd0);
        check("err_overrun", 64'(err_overrun), 64'(exp_ovr));
    endtask

    task automatic check_reset_outputs();
        check("rst_k_flat", 64'(k_flat), 64'd0);
        check("rst_x_flat", 64'(x_flat), 64'd0);
        check("rst_mvm_start", 64'(mvm_start), 64'd0);
        check("rst_tx_data", 64'(tx_data), 64'd0);
        check("rst_tx_valid", 64'(tx_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_err_overrun", 64'(err_overrun), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bq_t f;
        bq_t g;
        bq_t h;

        idle(3);
        rst = 1'b0;
        check_reset_outputs();

        // Reference frame from the block's bring-up vectors
        f = '{8'h1B, 8'hE4, 8'h00, 8'hFF, 8'h21, 8'h43};
        send_frame(f, 1'b0, 1'b1, 0);
        check("ref_k_flat", 64'(k_flat), 64'hFF00_E41B);
        check("ref_x_flat", 64'(x_flat), 64'h4321);
        do_result(40'h12_3456_789A, 0, 1'b0, 1'b0);

        send_frame(rand_bytes(NK + NX), 1'b1, 1'b0, 0);
        do_result(40'({$urandom, $urandom}), 2, 1'b0, 1'b1);

        send_frame(rand_bytes(NK + NX), 1'b1, 1'b1, 0);
        do_result(40'({$urandom, $urandom}), 1, 1'b1, 1'b0);

        // Abort mid-K
        for (int i = 0; i < 3; i++) send_byte(8'($urandom));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_ovr = 1'b0;
        check_reset_outputs();
        send_frame(f, 1'b0, 1'b0, 0);
        do_result(40'({$urandom, $urandom}), 1, 1'b0, 1'b0);

        // Stale partial frame followed by a long gap
        h = rand_bytes(2);
        send_byte(h[0]);
        send_byte(h[1]);
        idle(TMO + 2);
        g = rand_bytes(NK + NX);
`ifdef MVM_UART_SEQ_TIMEOUT_EN
        send_frame(g, 1'b0, 1'b0, 0);
`else
        for (int i = 0; i < NK + NX - 2; i++) h.push_back(g[i]);
        send_frame(h, 1'b0, 1'b0, 2);
        send_byte(g[NK+NX-2]);
        send_byte(g[NK+NX-1]);
        exp_ovr = 1'b1;
`endif
        do_result(40'({$urandom, $urandom}), 0, 1'b0, 1'b0);

        for (int n = 0; n < 5; n++) begin
            send_frame(rand_bytes(NK + NX), 1'b1, ($urandom_range(0, 1) == 1), 0);
            do_result(40'({$urandom, $urandom}), int'($urandom_range(0, 2)), 1'b0, 1'b0);
        end

        idle(4);
        check("start_queue_drained", 64'(exp_start_q.size()), 64'd0);
        check("tx_queue_drained", 64'(exp_tx_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
